// File: rtl/reset_domain_sequencer.sv
// Power-up / shutdown sequencer for the gated clock domains around the
// multi-domain reset synchronizer. Runs on the always-on domain 0 clock.
module reset_domain_sequencer #(
  parameter int CLOCKS         = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AUTO_START     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startup_req,
  input  logic              shutdown_req,
  input  logic              master_all_reset,
  input  logic [CLOCKS-1:0] domain_resn_sync,
  output logic              sync_resn_out,
  output logic [CLOCKS-2:0] clk_enable,
  output logic              running,
  output logic              busy,
  output logic              done_pulse,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_OFF, S_CLK_START, S_RELEASE, S_RUN, S_ASSERT, S_CLK_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              boot_q;
  logic              terr_q, terr_d;
  logic              sync_q, run_q, busy_q, done_q;
  logic [CLOCKS-2:0] en_q;
  logic              sync_d, en_d, run_d, busy_d, done_d;
  logic              settled, wait_to;

  assign settled = (cnt_q == SETTLE_LAST);
  assign wait_to = (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    terr_d  = terr_q;
    unique case (state_q)
      S_OFF: begin
        // boot_q is only set for the first cycle after rst when AUTO_START=1
        if (startup_req || pend_q || boot_q) begin
          state_d = S_CLK_START;
          pend_d  = 1'b0;
        end
      end
      S_CLK_START: begin
        if (shutdown_req)  state_d = S_ASSERT;
        else if (settled)  state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (shutdown_req)               state_d = S_ASSERT;
        else if (&domain_resn_sync)     state_d = S_RUN;
        else if (wait_to) begin
          state_d = S_ASSERT;
          terr_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (shutdown_req) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (shutdown_req)     pend_d = 1'b0;
        else if (startup_req) pend_d = 1'b1;
        if (master_all_reset) state_d = S_CLK_STOP;
        else if (wait_to) begin
          state_d = S_CLK_STOP;
          terr_d  = 1'b1;
        end
      end
      S_CLK_STOP: begin
        if (shutdown_req)     pend_d = 1'b0;
        else if (startup_req) pend_d = 1'b1;
        if (settled) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 1'b1;

    // Outputs are registered from the next state so they track the state register.
    sync_d = (state_d == S_RELEASE) || (state_d == S_RUN);
    en_d   = (state_d == S_CLK_START) || (state_d == S_RELEASE) ||
             (state_d == S_RUN) || (state_d == S_ASSERT);
    run_d  = (state_d == S_RUN);
    busy_d = (state_d == S_CLK_START) || (state_d == S_RELEASE) ||
             (state_d == S_ASSERT) || (state_d == S_CLK_STOP);
    done_d = (state_d != state_q) && ((state_d == S_RUN) || (state_d == S_OFF));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      boot_q  <= (AUTO_START != 0);
      terr_q  <= 1'b0;
      sync_q  <= 1'b0;
      en_q    <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      boot_q  <= 1'b0;
      terr_q  <= terr_d;
      sync_q  <= sync_d;
      en_q    <= {(CLOCKS-1){en_d}};
      run_q   <= run_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sync_resn_out = sync_q;
  assign clk_enable    = en_q;
  assign running       = run_q;
  assign busy          = busy_q;
  assign done_pulse    = done_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_reset_domain_sequencer.sv
// Bench for reset_domain_sequencer: expected outputs come from a per-scenario
// phase timeline built from the sequencing rules and random environment delays.
module tb_reset_domain_sequencer;
  localparam int CLOCKS = 3;
  localparam int P_RST = 0, P_OFF = 1, P_CST = 2, P_REL = 3, P_RUN = 4, P_ASS = 5, P_CSP = 6;
  localparam int R_NONE = 0, R_START = 1, R_SHUT = 2, R_BOTH = 3, R_RST = 4, R_UNRST = 8;

  typedef struct { int ph; int req; bit terr; } ent_t;

  logic clk = 1'b0, rst = 1'b1, rst_b = 1'b1;
  logic startup_req = 1'b0, start_b = 1'b0, shutdown_req = 1'b0, master_all_reset = 1'b0;
  logic [CLOCKS-1:0] domain_resn_sync = '0;
  logic sync_a, run_a, busy_a, done_a, terr_a;
  logic sync_b, run_b, busy_b, done_b, terr_b;
  logic [CLOCKS-2:0] en_a, en_b;

  reset_domain_sequencer #(.CLOCKS(CLOCKS), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(32), .AUTO_START(1)) u_auto (
    .clk(clk), .rst(rst), .startup_req(startup_req), .shutdown_req(shutdown_req),
    .master_all_reset(master_all_reset), .domain_resn_sync(domain_resn_sync),
    .sync_resn_out(sync_a), .clk_enable(en_a), .running(run_a), .busy(busy_a),
    .done_pulse(done_a), .timeout_err(terr_a));

  reset_domain_sequencer #(.CLOCKS(CLOCKS), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(32), .AUTO_START(0)) u_man (
    .clk(clk), .rst(rst_b), .startup_req(start_b), .shutdown_req(shutdown_req),
    .master_all_reset(master_all_reset), .domain_resn_sync(domain_resn_sync),
    .sync_resn_out(sync_b), .clk_enable(en_b), .running(run_b), .busy(busy_b),
    .done_pulse(done_b), .timeout_err(terr_b));

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  int hi_cnt = 0, lo_cnt = 0, rel_delay = 5, mar_delay = 7;
  logic [2:0] rel_val = 3'b111;
  ent_t tl[$];
  bit terr_m = 1'b0;
  int prev_ph = P_RST;

  // One clock; requests are single-cycle, and the synchronizer model releases
  // domains rel_delay cycles after the reset request rises and reports
  // all-in-reset mar_delay cycles after it falls.
  task automatic step();
    @(posedge clk); #1;
    startup_req = 1'b0; shutdown_req = 1'b0; start_b = 1'b0;
    if (sync_a) begin hi_cnt++; lo_cnt = 0; end
    else begin lo_cnt++; hi_cnt = 0; end
    domain_resn_sync = (sync_a && hi_cnt >= rel_delay) ? rel_val : 3'b000;
    master_all_reset = !sync_a && (lo_cnt >= mar_delay);
  endtask

  task automatic drive(int req);
    startup_req  = (req & 1) != 0;
    shutdown_req = (req & 2) != 0;
    if (req == R_RST) rst = 1'b1;
    else if (req == R_UNRST) rst = 1'b0;
  endtask

  task automatic plan(int ph, int n, int req);
    ent_t e;
    if (ph == P_RST) terr_m = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.ph = ph; e.terr = terr_m; e.req = (i == n - 1) ? req : R_NONE;
      tl.push_back(e);
    end
  endtask

  // Output table per phase: {sync_resn_out, clk_enable[1:0], running, busy, done_pulse, timeout_err}
  function automatic logic [6:0] expv(ent_t e, int prev);
    logic s, en, r, b, d;
    s  = (e.ph == P_REL) || (e.ph == P_RUN);
    en = (e.ph == P_CST) || (e.ph == P_REL) || (e.ph == P_RUN) || (e.ph == P_ASS);
    r  = (e.ph == P_RUN);
    b  = (e.ph == P_CST) || (e.ph == P_REL) || (e.ph == P_ASS) || (e.ph == P_CSP);
    d  = ((e.ph == P_RUN) || (e.ph == P_OFF)) && (prev != e.ph) && (prev != P_RST);
    return {s, en, en, r, b, d, e.terr};
  endfunction

  task automatic test_reset();
    ent_t e; logic [6:0] got, want;
    plan(P_RST, 3, R_UNRST);
    while (tl.size() > 0) begin
      e = tl.pop_front(); step();
      want = expv(e, prev_ph); prev_ph = e.ph;
      got = {sync_a, en_a, run_a, busy_a, done_a, terr_a};
      vecs++;
      if (got !== want) begin errs++; $display("FAIL reset ph=%0d got=%b want=%b", e.ph, got, want); end
      drive(e.req);
    end
  endtask

  task automatic test_startup();
    ent_t e; logic [6:0] got, want;
    rel_delay = 5; rel_val = 3'b111; mar_delay = 7;
    plan(P_CST, 4, R_NONE); plan(P_REL, 5, R_NONE);
    plan(P_RUN, 2, R_START); plan(P_RUN, 2, R_SHUT);
    while (tl.size() > 0) begin
      e = tl.pop_front(); step();
      want = expv(e, prev_ph); prev_ph = e.ph;
      got = {sync_a, en_a, run_a, busy_a, done_a, terr_a};
      vecs++;
      if (got !== want) begin errs++; $display("FAIL startup ph=%0d got=%b want=%b", e.ph, got, want); end
      drive(e.req);
    end
  endtask

  task automatic test_shutdown();
    ent_t e; logic [6:0] got, want;
    plan(P_ASS, 7, R_NONE); plan(P_CSP, 4, R_NONE);
    plan(P_OFF, 2, R_SHUT); plan(P_OFF, 3, R_NONE);
    while (tl.size() > 0) begin
      e = tl.pop_front(); step();
      want = expv(e, prev_ph); prev_ph = e.ph;
      got = {sync_a, en_a, run_a, busy_a, done_a, terr_a};
      vecs++;
      if (got !== want) begin errs++; $display("FAIL shutdown ph=%0d got=%b want=%b", e.ph, got, want); end
      drive(e.req);
    end
  endtask

  task automatic test_abort();
    ent_t e; logic [6:0] got, want;
    rel_delay = 10; mar_delay = 6;
    startup_req = 1'b1;
    plan(P_CST, 2, R_SHUT); plan(P_ASS, 1, R_NONE); plan(P_CSP, 4, R_NONE); plan(P_OFF, 2, R_START);
    plan(P_CST, 4, R_NONE); plan(P_REL, 3, R_SHUT); plan(P_ASS, 6, R_NONE);
    plan(P_CSP, 4, R_NONE); plan(P_OFF, 2, R_NONE);
    while (tl.size() > 0) begin
      e = tl.pop_front(); step();
      want = expv(e, prev_ph); prev_ph = e.ph;
      got = {sync_a, en_a, run_a, busy_a, done_a, terr_a};
      vecs++;
      if (got !== want) begin errs++; $display("FAIL abort ph=%0d got=%b want=%b", e.ph, got, want); end
      drive(e.req);
    end
  endtask

  task automatic test_pending();
    ent_t e; logic [6:0] got, want;
    rel_delay = 3; mar_delay = 5;
    startup_req = 1'b1;
    plan(P_CST, 4, R_NONE); plan(P_REL, 3, R_NONE); plan(P_RUN, 2, R_SHUT);
    plan(P_ASS, 5, R_NONE); plan(P_CSP, 1, R_START); plan(P_CSP, 3, R_NONE); plan(P_OFF, 1, R_NONE);
    plan(P_CST, 4, R_NONE); plan(P_REL, 3, R_NONE); plan(P_RUN, 1, R_BOTH);
    plan(P_ASS, 5, R_NONE); plan(P_CSP, 4, R_NONE); plan(P_OFF, 3, R_NONE);
    while (tl.size() > 0) begin
      e = tl.pop_front(); step();
      want = expv(e, prev_ph); prev_ph = e.ph;
      got = {sync_a, en_a, run_a, busy_a, done_a, terr_a};
      vecs++;
      if (got !== want) begin errs++; $display("FAIL pending ph=%0d got=%b want=%b", e.ph, got, want); end
      drive(e.req);
    end
  endtask

  task automatic test_back_to_back();
    ent_t e; logic [6:0] got, want;
    bit restart = 1'b0, pend, both;
    int run_n;
    for (int it = 0; it < 10; it++) begin
      if (!restart) startup_req = 1'b1;
      rel_delay = $urandom_range(1, 20);
      mar_delay = $urandom_range(1, 20);
      run_n     = $urandom_range(1, 4);
      both      = $urandom_range(0, 1) != 0;
      pend      = ($urandom_range(0, 1) != 0) && (mar_delay > 1) && (it != 9);
      plan(P_CST, 4, R_NONE); plan(P_REL, rel_delay, R_NONE);
      plan(P_RUN, run_n, both ? R_BOTH : R_SHUT);
      if (pend) begin plan(P_ASS, 1, R_START); plan(P_ASS, mar_delay - 1, R_NONE); end
      else plan(P_ASS, mar_delay, R_NONE);
      plan(P_CSP, 4, R_NONE);
      plan(P_OFF, pend ? 1 : 2, R_NONE);
      restart = pend;
      while (tl.size() > 0) begin
        e = tl.pop_front(); step();
        want = expv(e, prev_ph); prev_ph = e.ph;
        got = {sync_a, en_a, run_a, busy_a, done_a, terr_a};
        vecs++;
        if (got !== want) begin errs++; $display("FAIL back_to_back it=%0d ph=%0d got=%b want=%b", it, e.ph, got, want); end
        drive(e.req);
      end
    end
  endtask

  task automatic test_timeout();
    ent_t e; logic [6:0] got, want;
    rel_val = 3'b011; mar_delay = 7;
    startup_req = 1'b1;
    plan(P_CST, 4, R_NONE); plan(P_REL, 32, R_NONE);
    terr_m = 1'b1;
    plan(P_ASS, 7, R_NONE); plan(P_CSP, 4, R_NONE); plan(P_OFF, 3, R_NONE);
    while (tl.size() > 0) begin
      e = tl.pop_front(); step();
      want = expv(e, prev_ph); prev_ph = e.ph;
      got = {sync_a, en_a, run_a, busy_a, done_a, terr_a};
      vecs++;
      if (got !== want) begin errs++; $display("FAIL timeout ph=%0d got=%b want=%b", e.ph, got, want); end
      drive(e.req);
    end
    rel_val = 3'b111;
  endtask

  task automatic test_rst_mid();
    ent_t e; logic [6:0] got, want;
    rel_delay = 10;
    startup_req = 1'b1;
    plan(P_CST, 4, R_NONE); plan(P_REL, 3, R_RST); plan(P_RST, 1, R_UNRST);
    plan(P_CST, 4, R_NONE); plan(P_REL, 2, R_NONE);
    while (tl.size() > 0) begin
      e = tl.pop_front(); step();
      want = expv(e, prev_ph); prev_ph = e.ph;
      got = {sync_a, en_a, run_a, busy_a, done_a, terr_a};
      vecs++;
      if (got !== want) begin errs++; $display("FAIL rst_mid ph=%0d got=%b want=%b", e.ph, got, want); end
      drive(e.req);
    end
  endtask

  task automatic test_manual_start();
    logic [6:0] got;
    step(); rst_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      got = {sync_b, en_b, run_b, busy_b, done_b, terr_b};
      vecs++;
      if (got !== 7'b0000000) begin errs++; $display("FAIL manual_idle cyc=%0d got=%b want=0000000", i, got); end
    end
    start_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      got = {sync_b, en_b, run_b, busy_b, done_b, terr_b};
      vecs++;
      if (got !== 7'b0110100) begin errs++; $display("FAIL manual_clk_start cyc=%0d got=%b want=0110100", i, got); end
    end
    step();
    got = {sync_b, en_b, run_b, busy_b, done_b, terr_b};
    vecs++;
    if (got !== 7'b1110100) begin errs++; $display("FAIL manual_release got=%b want=1110100", got); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_shutdown();
    test_abort();
    test_pending();
    test_back_to_back();
    test_timeout();
    test_rst_mid();
    test_manual_start();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
